// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared types and constants for the ALU operand sequencer slice.
//   - seq_state_e : sequencer FSM states (IDLE -> READ -> EXEC -> WB)
//   - OP_*        : ALU opcode encodings driven on alu_oper
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } seq_state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_GT   = 3'd7;

endpackage

// File: rtl/alu_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_seq_regfile
//   NREG x DATA_W register file with two asynchronous read ports and a single
//   write port shared by direct loads and instruction write-back.
//   Ports:
//     clk, rst_n            clock, async active-low clear of every register
//     ld_we_i/addr/data     direct load request (FSM grants it only in IDLE)
//     wb_we_i/addr/data     write-back request (FSM raises it only in WB)
//     raddr_a_i/rdata_a_o   read port A (operand A)
//     raddr_b_i/rdata_b_o   read port B (operand B)
// -----------------------------------------------------------------------------
module alu_seq_regfile #(
    parameter  int DATA_W = 8,
    parameter  int NREG   = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_we_i,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NREG];

    // Load and write-back never coincide (IDLE vs WB); write-back wins anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we_i) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end else if (ld_we_i) begin
            regs_q[ld_addr_i] <= ld_data_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Operand-fetch / write-back stage feeding an external combinational ALU.
//   One register-to-register instruction every 4 clocks: IDLE -> READ -> EXEC
//   -> WB -> IDLE. R[rd] <= R[rd] op R[rs].
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     instr_valid/instr_ready          instruction handshake
//     instr_op/instr_rd/instr_rs       opcode, dest+operand A reg, operand B reg
//     ld_en/ld_addr/ld_data            direct register load (IDLE only)
//     alu_oper/alu_a/alu_b             registered ALU controls/operands
//     alu_out/alu_cy                   ALU result and carry
//     res_valid/res_data/res_cy        write-back pulse, last result, last carry
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NREG   = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [2:0]        alu_oper,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cy,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_cy
);

    seq_state_e        state_q, state_d;
    logic              accept;
    logic              ld_fire;
    logic              wb_we;

    logic [2:0]        op_q;
    logic [AW-1:0]     rd_q, rs_q;
    logic [2:0]        alu_oper_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_cy_q;
    logic [DATA_W-1:0] rf_a, rf_b;

    // A load in IDLE takes the cycle; the instruction waits one clock.
    assign instr_ready = (state_q == IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    assign ld_fire     = (state_q == IDLE) && ld_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        res_valid = 1'b0;
        wb_we     = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                res_valid = 1'b1;
                wb_we     = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers update only in READ so the ALU inputs stay stable
    // (no return to zero) while the sequencer is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            alu_oper_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_data_q <= '0;
            res_cy_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                rs_q <= instr_rs;
            end
            if (state_q == READ) begin
                alu_oper_q <= op_q;
                alu_a_q    <= rf_a;
                alu_b_q    <= rf_b;
            end
            if (state_q == EXEC) begin
                res_data_q <= alu_out;
                res_cy_q   <= alu_cy;
            end
        end
    end

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_we_i   (ld_fire),
        .ld_addr_i (ld_addr),
        .ld_data_i (ld_data),
        .wb_we_i   (wb_we),
        .wb_addr_i (rd_q),
        .wb_data_i (res_data_q),
        .raddr_a_i (rd_q),
        .rdata_a_o (rf_a),
        .raddr_b_i (rs_q),
        .rdata_b_o (rf_b)
    );

    assign alu_oper = alu_oper_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign res_data = res_data_q;
    assign res_cy   = res_cy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Bench for alu_op_sequencer with a behavioural 8-bit ALU alongside.
//   A transaction-level model computes each instruction's result at accept
//   time and releases it on the cycle-since-accept schedule.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = '0;
    logic [1:0] instr_rd = '0;
    logic [1:0] instr_rs = '0;
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [2:0] alu_oper;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_cy;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_cy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_W (8),
        .NREG   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_oper    (alu_oper),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_cy      (alu_cy),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_cy      (res_cy)
    );

    // Behavioural ALU: returns {carry, result}. SUB/DEC carry is the borrow.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + 9'd1;
            3'd2:    return {1'b0, a} - {1'b0, b};
            3'd3:    return {1'b0, a} - 9'd1;
            3'd4:    return {a, 1'b0};
            3'd5:    return {a[0], 1'b0, a[7:1]};
            3'd6:    return {1'b0, ~(a & b)};
            default: return {8'd0, (a > b)};
        endcase
    endfunction

    assign {alu_cy, alu_out} = alu_f(alu_oper, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_r [4];
    int         ph;            // clocks since accept: 0 = idle
    logic [7:0] p_a, p_b, p_res;
    logic [2:0] p_op;
    logic [1:0] p_rd;
    logic       p_cy;
    logic [7:0] e_a, e_b, e_res;
    logic [2:0] e_op;
    logic       e_cy;
    logic [8:0] acc_res;

    assign acc_res = alu_f(instr_op, m_r[instr_rd], m_r[instr_rs]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_r[i] <= '0;
            ph <= 0;
            e_a <= '0; e_b <= '0; e_op <= '0; e_res <= '0; e_cy <= 1'b0;
            p_a <= '0; p_b <= '0; p_op <= '0; p_res <= '0; p_cy <= 1'b0; p_rd <= '0;
        end else begin
            case (ph)
                0: begin
                    if (ld_en) begin
                        m_r[ld_addr] <= ld_data;
                    end else if (instr_valid) begin
                        p_a   <= m_r[instr_rd];
                        p_b   <= m_r[instr_rs];
                        p_op  <= instr_op;
                        p_rd  <= instr_rd;
                        p_res <= acc_res[7:0];
                        p_cy  <= acc_res[8];
                        ph    <= 1;
                    end
                end
                1: begin
                    e_a <= p_a; e_b <= p_b; e_op <= p_op;
                    ph  <= 2;
                end
                2: begin
                    e_res <= p_res; e_cy <= p_cy;
                    ph    <= 3;
                end
                default: begin
                    m_r[p_rd] <= p_res;
                    ph        <= 0;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    typedef struct {
        logic [7:0] d;
        logic       c;
    } res_t;
    res_t rq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("instr_ready", instr_ready, (ph == 0) && !ld_en);
            chk("res_valid", res_valid, ph == 3);
            chk("res_data", res_data, e_res);
            chk("res_cy", res_cy, e_cy);
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
            chk("alu_oper", alu_oper, e_op);
            for (int i = 0; i < 4; i++)
                chk($sformatf("R%0d", i), dut.u_rf.regs_q[i], m_r[i]);
            if (res_valid) rq.push_back('{res_data, res_cy});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cyc(1);
        ld_en = 1'b0;
    endtask

    task automatic do_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            output time t_acc);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs;
        t_acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (instr_ready) begin
                @(posedge clk);
                t_acc = $time;
                #1;
                break;
            end
        end
        instr_valid = 1'b0;
        if (t_acc == 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic get_res(output logic [7:0] d, output logic c);
        for (int k = 0; k < 20 && rq.size() == 0; k++) cyc(1);
        if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL result_timeout: got no res_valid expected one within 20 cycles");
            d = 'x; c = 1'bx;
        end else begin
            d = rq[0].d; c = rq[0].c;
            void'(rq.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        time        t1, t2;
        int         lat, lows;
        logic [7:0] d;
        logic       c;

        #12;
        chk("rst_ready", instr_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_cy", res_cy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_oper", alu_oper, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_R%0d", i), dut.u_rf.regs_q[i], 0);
        #5 rst_n = 1'b1;
        cyc(1);

        // 1: ADD with carry out, latency to res_valid
        do_load(2'd0, 8'hFF);
        do_load(2'd1, 8'h09);
        do_instr(3'd0, 2'd0, 2'd1, t1);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); lat++;
            if (res_valid) break;
        end
        chk("t1_latency", lat, 3);
        get_res(d, c);
        chk("t1_res_data", d, 8'h08);
        chk("t1_res_cy", c, 1);
        cyc(1);
        chk("t1_R0", dut.u_rf.regs_q[0], 8'h08);

        // 2: SUB then back-to-back instruction
        do_load(2'd2, 8'h25);
        do_load(2'd3, 8'h03);
        do_instr(3'd2, 2'd2, 2'd3, t1);
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 2'd3; instr_rs = 2'd3;
        lows = 0; t2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!instr_ready) lows++;
            else begin
                @(posedge clk); t2 = $time; #1;
                break;
            end
        end
        instr_valid = 1'b0;
        chk("t2_ready_low_cycles", lows, 3);
        chk("t2_next_accept_gap", 32'(t2 - t1), 40);
        get_res(d, c);
        chk("t2_res_data", d, 8'h22);
        chk("t2_res_cy", c, 0);
        get_res(d, c);
        chk("t2b_res_data", d, 8'h06);

        // 3: NAND, then rd==rs reading the updated register
        do_load(2'd1, 8'hAA);
        do_load(2'd2, 8'h5A);
        do_instr(3'd6, 2'd1, 2'd2, t1);
        get_res(d, c);
        chk("t3_nand1", d, 8'hF5);
        do_instr(3'd6, 2'd1, 2'd1, t1);
        get_res(d, c);
        chk("t3_nand2", d, 8'h0A);

        // 4: load wins over instruction in the same IDLE cycle; load during EXEC dropped
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'h77;
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 2'd0; instr_rs = 2'd0;
        @(negedge clk);
        chk("t4_ready_during_load", instr_ready, 0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
        chk("t4_ready_next", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        cyc(1);
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h99;
        cyc(1);
        ld_en = 1'b0;
        get_res(d, c);
        chk("t4_res_data", d, 8'h10);
        chk("t4_R3_loaded", dut.u_rf.regs_q[3], 8'h77);
        chk("t4_R2_unchanged", dut.u_rf.regs_q[2], 8'h5A);

        // 5: reset during EXEC aborts the instruction
        do_instr(3'd0, 2'd1, 2'd2, t1);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_alu_a", alu_a, 0);
        chk("t5_alu_b", alu_b, 0);
        chk("t5_alu_oper", alu_oper, 0);
        chk("t5_res_data", res_data, 0);
        chk("t5_res_cy", res_cy, 0);
        chk("t5_res_valid", res_valid, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_R%0d", i), dut.u_rf.regs_q[i], 0);
        @(posedge clk); #3 rst_n = 1'b1;
        cyc(5);
        chk("t5_no_writeback", rq.size(), 0);
        chk("t5_ready_after", instr_ready, 1);
        chk("t5_R1_zero", dut.u_rf.regs_q[1], 0);

        // 6: compare opcode writes back like any other
        do_load(2'd0, 8'h13);
        do_load(2'd1, 8'h12);
        do_instr(3'd7, 2'd0, 2'd1, t1);
        get_res(d, c);
        chk("t6_gt_res", d, 8'h01);
        chk("t6_R0", dut.u_rf.regs_q[0], 8'h01);
        cyc(3);
        chk("t6_single_pulse", rq.size(), 0);

        // Random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 600; n++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_op    = 3'($urandom_range(0, 7));
            instr_rd    = 2'($urandom_range(0, 3));
            instr_rs    = 2'($urandom_range(0, 3));
            ld_en       = ($urandom_range(0, 4) == 0);
            ld_addr     = 2'($urandom_range(0, 3));
            ld_data     = 8'($urandom_range(0, 255));
            cyc(1);
        end
        instr_valid = 1'b0;
        ld_en = 1'b0;
        cyc(6);
        rq.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
